// File: rtl/keypad_event_fifo.sv
// Keypad front end: synchronizes the raw key vector, debounces it, turns new
// presses into 4-bit key codes and queues them in a 4-entry first-word
// fall-through FIFO with a sticky overflow flag.
module keypad_event_fifo #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_in,
    input  logic        key_rd,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        key_multi,
    output logic        key_ovf
);

    localparam logic [19:0] CNT_MAX = 20'(DB_CYCLES - 1);

    logic [15:0] r_sync1;
    logic [15:0] r_sync;
    logic [15:0] r_cand;
    logic [19:0] r_cnt;
    logic [15:0] r_stable;
    logic        r_down;
    logic        r_multi;
    logic        r_ovf;
    logic [2:0]  r_wrPtr;
    logic [2:0]  r_rdPtr;
    logic [3:0]  r_mem [4];

    logic        w_load;
    logic [15:0] w_newPress;
    logic        w_push;
    logic [3:0]  w_pushCode;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wrEn;

    // Two-flop synchronizer: key_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync  <= '0;
        end else begin
            r_sync1 <= key_in;
            r_sync  <= r_sync1;
        end
    end

    // Debouncer: a candidate must stay unchanged for DB_CYCLES clocks; the
    // counter then saturates and stable keeps being refreshed from cand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (r_sync != r_cand) begin
            r_cand <= r_sync;
            r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_cand;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

    assign w_load     = (r_sync == r_cand) && (r_cnt == CNT_MAX);
    assign w_newPress = w_load ? (r_cand & ~r_stable) : 16'h0000;
    assign w_push     = |w_newPress;

    // Lowest set bit of the new-press vector wins; other new bits are dropped.
    always_comb begin
        w_pushCode = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_newPress[i]) begin
                w_pushCode = 4'(i);
            end
        end
    end

    // Status outputs follow stable with one clock of delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_down  <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_down  <= |r_stable;
            r_multi <= (r_stable & (r_stable - 16'd1)) != 16'h0000;
        end
    end

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[2] != r_rdPtr[2]) && (r_wrPtr[1:0] == r_rdPtr[1:0]);
    assign w_pop   = key_rd && !w_empty;
    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign w_wrEn  = w_push && (!w_full || w_pop);

    // FIFO pointers, storage and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wrEn) begin
                r_mem[r_wrPtr[1:0]] <= w_pushCode;
                r_wrPtr             <= r_wrPtr + 3'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 3'd1;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign key_valid = !w_empty;
    assign key_code  = w_empty ? 4'd0 : r_mem[r_rdPtr[1:0]];
    assign key_down  = r_down;
    assign key_multi = r_multi;
    assign key_ovf   = r_ovf;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Testbench for keypad_event_fifo with a short debounce time: a vector table
// for the basic press/release behaviour, hand-written multi-cycle scenarios,
// and a randomized run against a queue-based reference model.
module tb_keypad_event_fifo;

    localparam int DB = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] key_in;
    logic        key_rd;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic        key_multi;
    logic        key_ovf;

    int testCount;
    int failCount;

    keypad_event_fifo #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_rd    (key_rd),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down),
        .key_multi (key_multi),
        .key_ovf   (key_ovf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guards against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string       name;
        logic [15:0] key;
        logic        rd;
        int          cycles;
        logic        expValid;
        logic [3:0]  expCode;
        logic        expDown;
        logic        expMulti;
        logic        expOvf;
    } vec_t;

    vec_t vecs [8];

    // Reference model state.
    logic [15:0] mS1, mS2, mRunVal, mDeb;
    int          mRunLen;
    logic        mDown, mMulti, mOvf;
    logic [3:0]  mQ [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        key_in = 16'h0000;
        key_rd = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pressRelease(input int code);
        key_in = 16'h0001 << code;
        repeat (8) tick();
        key_in = 16'h0000;
        repeat (8) tick();
    endtask

    task automatic popOne();
        key_rd = 1'b1;
        tick();
        key_rd = 1'b0;
    endtask

    task automatic waitValid(input int bound, output int edges);
        edges = 0;
        while (!key_valid && edges < bound) begin
            tick();
            edges++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        key_in = v.key;
        key_rd = v.rd;
        repeat (v.cycles) tick();
        key_rd = 1'b0;
        checkOutput({v.name, ".valid"}, 32'(key_valid), 32'(v.expValid));
        checkOutput({v.name, ".code"},  32'(key_code),  32'(v.expCode));
        checkOutput({v.name, ".down"},  32'(key_down),  32'(v.expDown));
        checkOutput({v.name, ".multi"}, 32'(key_multi), 32'(v.expMulti));
        checkOutput({v.name, ".ovf"},   32'(key_ovf),   32'(v.expOvf));
    endtask

    function automatic logic [3:0] lowestBit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic int onesCount(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // The debounced vector takes a value once the synchronized input has
    // shown it on DB+1 consecutive edges; each newly pressed set produces one
    // event (its lowest key) in a 4-deep queue.
    task automatic modelReset();
        mS1 = '0; mS2 = '0; mRunVal = '0; mDeb = '0; mRunLen = 0;
        mDown = 1'b0; mMulti = 1'b0; mOvf = 1'b0;
        mQ.delete();
    endtask

    task automatic modelEdge(input logic [15:0] k, input logic rd);
        logic [15:0] s;
        logic [15:0] newP;
        logic        nextDown, nextMulti, wasFull, doPop;
        s = mS2;
        mS2 = mS1;
        mS1 = k;
        nextDown  = (mDeb != 16'h0000);
        nextMulti = (onesCount(mDeb) > 1);
        if (s == mRunVal) begin
            if (mRunLen < 1000) mRunLen++;
        end else begin
            mRunVal = s;
            mRunLen = 1;
        end
        newP = 16'h0000;
        if (mRunLen >= DB + 1) begin
            newP = mRunVal & ~mDeb;
            mDeb = mRunVal;
        end
        wasFull = (mQ.size() == 4);
        doPop   = rd && (mQ.size() != 0);
        if (doPop) void'(mQ.pop_front());
        if (newP != 16'h0000) begin
            if (wasFull && !doPop) mOvf = 1'b1;
            else mQ.push_back(lowestBit(newP));
        end
        mDown  = nextDown;
        mMulti = nextMulti;
    endtask

    initial begin
        int          edges;
        logic        sawValid;
        logic [15:0] pattern;
        logic [31:0] rnd;
        int          rdOdds;

        testCount = 0;
        failCount = 0;
        rst_n  = 1'b0;
        key_in = 16'h0000;
        key_rd = 1'b0;

        vecs[0] = '{"press_wait",    16'h0020, 1'b0, 6, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{"press_event",   16'h0020, 1'b0, 1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{"press_down",    16'h0020, 1'b0, 1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{"press_pop",     16'h0020, 1'b1, 1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{"release",       16'h0000, 1'b0, 8, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{"multi_press",   16'hC400, 1'b0, 8, 1'b1, 4'd10, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{"multi_pop",     16'h0000, 1'b1, 1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[7] = '{"multi_release", 16'h0000, 1'b0, 7, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};

        // Reset state.
        doReset();
        checkOutput("reset.valid", 32'(key_valid), 32'd0);
        checkOutput("reset.code",  32'(key_code),  32'd0);
        checkOutput("reset.down",  32'(key_down),  32'd0);
        checkOutput("reset.multi", 32'(key_multi), 32'd0);
        checkOutput("reset.ovf",   32'(key_ovf),   32'd0);

        // Table-driven single and simultaneous presses.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Bouncing input: no event while toggling, one event once it holds.
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_in = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            if (key_valid) sawValid = 1'b1;
        end
        checkOutput("bounce.no_event", 32'(sawValid), 32'd0);
        key_in = 16'h0001;
        waitValid(20, edges);
        checkOutput("bounce.latency", 32'(edges), 32'(DB + 3));
        checkOutput("bounce.code", 32'(key_code), 32'd0);
        popOne();
        repeat (6) tick();
        checkOutput("bounce.single_event", 32'(key_valid), 32'd0);
        key_in = 16'h0000;
        repeat (8) tick();

        // Overflow: five presses into a 4-deep FIFO without reading.
        for (int c = 1; c <= 4; c++) pressRelease(c);
        checkOutput("ovf.before", 32'(key_ovf), 32'd0);
        pressRelease(5);
        checkOutput("ovf.set", 32'(key_ovf), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("ovf.pop%0d.valid", c), 32'(key_valid), 32'd1);
            checkOutput($sformatf("ovf.pop%0d.code", c), 32'(key_code), 32'(c));
            popOne();
        end
        checkOutput("ovf.drained", 32'(key_valid), 32'd0);
        checkOutput("ovf.sticky", 32'(key_ovf), 32'd1);

        // Full FIFO with a pop on the same edge as the push of code 9.
        doReset();
        for (int c = 1; c <= 4; c++) pressRelease(c);
        key_in = 16'h0200;
        repeat (6) tick();
        checkOutput("fullpop.head_before", 32'(key_code), 32'd1);
        key_rd = 1'b1;
        tick();
        key_rd = 1'b0;
        checkOutput("fullpop.ovf", 32'(key_ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] expCode;
            expCode = (i == 3) ? 4'd9 : 4'(i + 2);
            checkOutput($sformatf("fullpop.pop%0d", i), 32'(key_code), 32'(expCode));
            popOne();
        end
        checkOutput("fullpop.drained", 32'(key_valid), 32'd0);
        key_in = 16'h0000;
        repeat (8) tick();

        // Asynchronous reset with two queued entries and a key held.
        doReset();
        pressRelease(6);
        pressRelease(7);
        checkOutput("rst.queued", 32'(key_code), 32'd6);
        key_in = 16'h0100;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async_valid", 32'(key_valid), 32'd0);
        checkOutput("rst.async_code",  32'(key_code),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitValid(20, edges);
        checkOutput("rst.held_latency", 32'(edges), 32'(DB + 3));
        checkOutput("rst.held_code", 32'(key_code), 32'd8);
        popOne();
        repeat (12) tick();
        checkOutput("rst.single_event", 32'(key_valid), 32'd0);

        // Randomized run against the reference model.
        doReset();
        modelReset();
        pattern = 16'h0000;
        for (int n = 0; n < 1200; n++) begin
            rdOdds = (n < 600) ? 40 : 4;
            if ($urandom_range(0, 9) == 0) begin
                rnd = $urandom();
                case ($urandom_range(0, 3))
                    0: pattern = 16'h0000;
                    1: pattern = 16'h0001 << $urandom_range(0, 15);
                    2: pattern = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                    default: pattern = rnd[15:0];
                endcase
            end
            key_in = pattern;
            key_rd = ($urandom_range(0, rdOdds - 1) == 0);
            @(posedge clk);
            modelEdge(key_in, key_rd);
            #1;
            checkOutput("rand.valid", 32'(key_valid), 32'(mQ.size() != 0));
            checkOutput("rand.code",  32'(key_code),  32'((mQ.size() != 0) ? mQ[0] : 4'd0));
            checkOutput("rand.down",  32'(key_down),  32'(mDown));
            checkOutput("rand.multi", 32'(key_multi), 32'(mMulti));
            checkOutput("rand.ovf",   32'(key_ovf),   32'(mOvf));
        end
        key_rd = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
